pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Keeps its own shadow pipeline of destination-register tags for EX, MEM and WB.
- From those tags it drives load-use stalls, branch flushes, EX-stage forwarding selects and hazard performance counters.
- Sits beside the IF/ID, ID/EX and EX/MEM registers; replaces ad-hoc PCSrc/AND logic in the top level.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/fwd_match.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and encodings for the pipeline hazard/forwarding controller.
package pipe_pkg;

    // Per-stage tag flags; the destination address is added by the user
    // because its width is a module parameter.
    typedef struct packed {
        logic valid;
        logic regWrite;
    } tag_flags_t;

    // EX-stage operand source selects.
    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_EXMEM   = 2'b01,
        FWD_MEMWB   = 2'b10
    } fwd_sel_e;

    // Stage that resolves branches.
    localparam int unsigned BR_ID  = 1;
    localparam int unsigned BR_EX  = 2;
    localparam int unsigned BR_MEM = 3;

    // Encoding loaded into IF/ID on a flush (sll $0,$0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fwd_match.sv
// Compares one EX-stage source register against the MEM and WB producers
// and returns the forwarding select for that operand.
module fwd_match
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] srcAddr,
    input  logic              srcUsed,
    input  logic              memWrites,
    input  logic [REG_AW-1:0] memDst,
    input  logic              wbWrites,
    input  logic [REG_AW-1:0] wbDst,
    output logic [1:0]        sel
);

    logic srcLive;
    logic memHit;
    logic wbHit;

    // Youngest producer (MEM) wins over WB; register 0 never forwards.
    always_comb begin
        srcLive = srcUsed && (srcAddr != '0);
        memHit  = srcLive && memWrites && (memDst == srcAddr);
        wbHit   = srcLive && wbWrites && (wbDst == srcAddr);
        sel     = FWD_REGFILE;
        if (memHit) begin
            sel = FWD_EXMEM;
        end else if (wbHit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: tracks
// destination tags for EX/MEM/WB, drives stalls, flushes, forwarding
// selects and saturating hazard counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned BR_STAGE = 3,
    parameter int unsigned FWD_EN   = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_dst_addr,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      br_resolve,
    input  logic                      br_taken,
    input  logic                      ext_stall,
    output logic                      pc_write_en,
    output logic                      ifid_write_en,
    output logic                      ifid_flush,
    output logic                      idex_bubble,
    output logic                      exmem_bubble,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic [CNT_W-1:0]          load_use_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    typedef struct packed {
        tag_flags_t               f;
        logic                     memRead;
        logic [REG_AW-1:0]        dst;
        logic [NUM_SRC*REG_AW-1:0] src;
        logic [NUM_SRC-1:0]       used;
    } ex_tag_t;

    // Loads in MEM/WB already deliver their data, so mem_read is not kept there.
    typedef struct packed {
        tag_flags_t        f;
        logic [REG_AW-1:0] dst;
    } tag_t;

    ex_tag_t exTag;
    tag_t    memTag;
    tag_t    wbTag;

    logic loadUse;
    logic brTaken;
    logic incLoadUse;
    logic incFlush;
    logic [NUM_SRC-1:0][1:0] matchSel;

    function automatic logic regHit(input tag_flags_t f, input logic [REG_AW-1:0] dst,
                                    input logic [REG_AW-1:0] src, input logic used);
        return f.valid && f.regWrite && used && (src != '0) && (dst == src);
    endfunction

    // Load-use detection (every RAW on EX/MEM when forwarding is disabled).
    always_comb begin
        loadUse = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (regHit(exTag.f, exTag.dst, id_src_addr[i*REG_AW +: REG_AW], id_src_used[i])
                && (exTag.memRead || (FWD_EN == 0))) begin
                loadUse = 1'b1;
            end
            if ((FWD_EN == 0)
                && regHit(memTag.f, memTag.dst, id_src_addr[i*REG_AW +: REG_AW], id_src_used[i])) begin
                loadUse = 1'b1;
            end
        end
        if (!id_valid) begin
            loadUse = 1'b0;
        end
    end

    // Pipeline enables: reset, then freeze, then taken branch, then load-use stall.
    always_comb begin
        brTaken       = br_resolve && br_taken;
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_bubble  = 1'b0;
        incLoadUse    = 1'b0;
        incFlush      = 1'b0;
        if (!Rst_n || ext_stall) begin
            // everything held low
        end else if (brTaken) begin
            pc_write_en   = 1'b1;
            ifid_write_en = 1'b1;
            ifid_flush    = 1'b1;
            idex_bubble   = (BR_STAGE >= BR_EX);
            exmem_bubble  = (BR_STAGE == BR_MEM);
            incFlush      = 1'b1;
        end else if (loadUse) begin
            idex_bubble = 1'b1;
            incLoadUse  = 1'b1;
        end else begin
            pc_write_en   = 1'b1;
            ifid_write_en = 1'b1;
        end
    end

    // Shadow tag pipeline; bubbles invalidate wrong-path or stalled entries.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            exTag  <= '0;
            memTag <= '0;
            wbTag  <= '0;
        end else if (!ext_stall) begin
            wbTag             <= memTag;
            memTag.f.valid    <= exTag.f.valid && !exmem_bubble;
            memTag.f.regWrite <= exTag.f.regWrite;
            memTag.dst        <= exTag.dst;
            if (idex_bubble || !id_valid) begin
                exTag <= '0;
            end else begin
                exTag.f.valid    <= 1'b1;
                exTag.f.regWrite <= id_reg_write;
                exTag.memRead    <= id_mem_read;
                exTag.dst        <= id_dst_addr;
                exTag.src        <= id_src_addr;
                exTag.used       <= id_src_used;
            end
        end
    end

    // Saturating hazard counters.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            load_use_cnt <= '0;
            flush_cnt    <= '0;
        end else begin
            if (incLoadUse && (load_use_cnt != '1)) begin
                load_use_cnt <= load_use_cnt + CNT_W'(1);
            end
            if (incFlush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : gFwd
        fwd_match #(.REG_AW(REG_AW)) uMatch (
            .srcAddr   (exTag.src[g*REG_AW +: REG_AW]),
            .srcUsed   (exTag.f.valid && exTag.used[g]),
            .memWrites (memTag.f.valid && memTag.f.regWrite),
            .memDst    (memTag.dst),
            .wbWrites  (wbTag.f.valid && wbTag.f.regWrite),
            .wbDst     (wbTag.dst),
            .sel       (matchSel[g])
        );
    end

    // Forwarding selects, forced to regfile in reset or when forwarding is off.
    always_comb begin
        fwd_sel = '0;
        if (Rst_n && (FWD_EN != 0)) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                fwd_sel[2*i +: 2] = matchSel[i];
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: DUT A (forwarding, MEM-stage branches, 16-bit counters)
// and DUT B (no forwarding, EX-stage branches, 4-bit counters).
module tb_pipe_hazard_ctrl;

    logic       Clk = 1'b0;
    logic       rstA, rstB;
    logic       idValid;
    logic [9:0] idSrc;
    logic [1:0] idUsed;
    logic [4:0] idDst;
    logic       idRw, idMr, brRes, brTak, extStall;

    logic        pcA, ifwA, flA, idbA, exbA;
    logic [3:0]  fwdA;
    logic [15:0] luA, fcA;
    logic        pcB, ifwB, flB, idbB, exbB;
    logic [3:0]  fwdB;
    logic [3:0]  luB, fcB;

    int unsigned nTests = 0;
    int unsigned nFail  = 0;

    always #5 Clk = ~Clk;

    pipe_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .BR_STAGE(3), .FWD_EN(1), .CNT_W(16)) dutA (
        .Clk(Clk), .Rst_n(rstA), .id_valid(idValid), .id_src_addr(idSrc), .id_src_used(idUsed),
        .id_dst_addr(idDst), .id_reg_write(idRw), .id_mem_read(idMr), .br_resolve(brRes),
        .br_taken(brTak), .ext_stall(extStall), .pc_write_en(pcA), .ifid_write_en(ifwA),
        .ifid_flush(flA), .idex_bubble(idbA), .exmem_bubble(exbA), .fwd_sel(fwdA),
        .load_use_cnt(luA), .flush_cnt(fcA)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .BR_STAGE(2), .FWD_EN(0), .CNT_W(4)) dutB (
        .Clk(Clk), .Rst_n(rstB), .id_valid(idValid), .id_src_addr(idSrc), .id_src_used(idUsed),
        .id_dst_addr(idDst), .id_reg_write(idRw), .id_mem_read(idMr), .br_resolve(brRes),
        .br_taken(brTak), .ext_stall(extStall), .pc_write_en(pcB), .ifid_write_en(ifwB),
        .ifid_flush(flB), .idex_bubble(idbB), .exmem_bubble(exbB), .fwd_sel(fwdB),
        .load_use_cnt(luB), .flush_cnt(fcB)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] s0, s1;
        logic [1:0] used;
        logic [4:0] dst;
        logic       rw, mr;
    } instr_t;

    // {pc_write_en, ifid_write_en, ifid_flush, idex_bubble, exmem_bubble}
    typedef logic [4:0] ctl_t;
    localparam ctl_t RUN   = 5'b11000;
    localparam ctl_t STALL = 5'b00010;
    localparam ctl_t OFF   = 5'b00000;
    localparam ctl_t BR3   = 5'b11111;
    localparam ctl_t BR2   = 5'b11110;

    typedef struct {
        string       name;
        int unsigned dut;
        ctl_t        ctl;
        logic [3:0]  fwd;
        logic [15:0] lu, fc;
    } exp_t;

    exp_t sb[$];

    function automatic instr_t mk(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                                  input logic [4:0] dst, input logic rw, input logic mr);
        return {1'b1, s0, s1, used, dst, rw, mr};
    endfunction

    localparam instr_t IDLE  = '0;
    instr_t LW8, ADD8, ADD3, SUB4, ADD5, OR6, LD0, RD0, LW8U, RD8U;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string name, input int unsigned dut, input logic rst, input instr_t ins,
                       input logic brr, input logic brt, input logic xs, input ctl_t ctl,
                       input logic [3:0] fwd, input logic [15:0] lu, input logic [15:0] fc);
        exp_t e;
        exp_t o;
        if (dut == 0) rstA = rst; else rstB = rst;
        idValid  = ins.v;
        idSrc    = {ins.s1, ins.s0};
        idUsed   = ins.used;
        idDst    = ins.dst;
        idRw     = ins.rw;
        idMr     = ins.mr;
        brRes    = brr;
        brTak    = brt;
        extStall = xs;
        e.name = name; e.dut = dut; e.ctl = ctl; e.fwd = fwd; e.lu = lu; e.fc = fc;
        sb.push_back(e);
        @(negedge Clk);
        o = sb.pop_front();
        if (o.dut == 0) begin
            checkVal({o.name, ".ctl"}, {27'b0, pcA, ifwA, flA, idbA, exbA}, {27'b0, o.ctl});
            checkVal({o.name, ".fwd"}, {28'b0, fwdA}, {28'b0, o.fwd});
            checkVal({o.name, ".luCnt"}, {16'b0, luA}, {16'b0, o.lu});
            checkVal({o.name, ".flCnt"}, {16'b0, fcA}, {16'b0, o.fc});
        end else begin
            checkVal({o.name, ".ctl"}, {27'b0, pcB, ifwB, flB, idbB, exbB}, {27'b0, o.ctl});
            checkVal({o.name, ".fwd"}, {28'b0, fwdB}, {28'b0, o.fwd});
            checkVal({o.name, ".luCnt"}, {28'b0, luB}, {16'b0, o.lu});
            checkVal({o.name, ".flCnt"}, {28'b0, fcB}, {16'b0, o.fc});
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic pad(input int unsigned dut, input logic [15:0] lu, input logic [15:0] fc);
        for (int i = 0; i < 3; i++) cyc("pad", dut, 1'b1, IDLE, 0, 0, 0, RUN, 4'b0000, lu, fc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned eLu;
        LW8  = mk(5'd1, 5'd2, 2'b11, 5'd8,  1'b1, 1'b1);
        ADD8 = mk(5'd8, 5'd2, 2'b11, 5'd9,  1'b1, 1'b0);
        ADD3 = mk(5'd1, 5'd2, 2'b11, 5'd3,  1'b1, 1'b0);
        SUB4 = mk(5'd3, 5'd3, 2'b11, 5'd4,  1'b1, 1'b0);
        ADD5 = mk(5'd1, 5'd2, 2'b11, 5'd5,  1'b1, 1'b0);
        OR6  = mk(5'd5, 5'd0, 2'b11, 5'd6,  1'b1, 1'b0);
        LD0  = mk(5'd1, 5'd2, 2'b11, 5'd0,  1'b1, 1'b1);
        RD0  = mk(5'd0, 5'd0, 2'b11, 5'd7,  1'b1, 1'b0);
        LW8U = mk(5'd1, 5'd2, 2'b00, 5'd8,  1'b1, 1'b1);
        RD8U = mk(5'd2, 5'd8, 2'b01, 5'd10, 1'b1, 1'b0);

        rstA = 1'b0; rstB = 1'b0;
        idValid = 1'b0; idSrc = '0; idUsed = '0; idDst = '0; idRw = 1'b0; idMr = 1'b0;
        brRes = 1'b0; brTak = 1'b0; extStall = 1'b0;
        repeat (2) @(posedge Clk);
        #1;

        // DUT A: reset state
        cyc("A_rst", 0, 1'b0, IDLE, 0, 0, 0, OFF, 4'b0000, 16'd0, 16'd0);
        pad(0, 16'd0, 16'd0);

        // Load-use: lw $8 then add reading $8
        cyc("lu_lw",   0, 1'b1, LW8,  0, 0, 0, RUN,   4'b0000, 16'd0, 16'd0);
        cyc("lu_stl",  0, 1'b1, ADD8, 0, 0, 0, STALL, 4'b0000, 16'd0, 16'd0);
        cyc("lu_go",   0, 1'b1, ADD8, 0, 0, 0, RUN,   4'b0000, 16'd1, 16'd0);
        cyc("lu_fwd",  0, 1'b1, IDLE, 0, 0, 0, RUN,   4'b0010, 16'd1, 16'd0);
        pad(0, 16'd1, 16'd0);

        // ALU forwarding back-to-back, no stall
        cyc("alu_add", 0, 1'b1, ADD3, 0, 0, 0, RUN, 4'b0000, 16'd1, 16'd0);
        cyc("alu_sub", 0, 1'b1, SUB4, 0, 0, 0, RUN, 4'b0000, 16'd1, 16'd0);
        cyc("alu_fwd", 0, 1'b1, IDLE, 0, 0, 0, RUN, 4'b0101, 16'd1, 16'd0);
        pad(0, 16'd1, 16'd0);

        // MEM producer beats WB producer of the same register
        cyc("pri_a",   0, 1'b1, ADD5, 0, 0, 0, RUN, 4'b0000, 16'd1, 16'd0);
        cyc("pri_b",   0, 1'b1, ADD5, 0, 0, 0, RUN, 4'b0000, 16'd1, 16'd0);
        cyc("pri_rd",  0, 1'b1, OR6,  0, 0, 0, RUN, 4'b0000, 16'd1, 16'd0);
        cyc("pri_fwd", 0, 1'b1, IDLE, 0, 0, 0, RUN, 4'b0001, 16'd1, 16'd0);
        pad(0, 16'd1, 16'd0);

        // Register 0 is never a hazard
        cyc("r0_ld",   0, 1'b1, LD0,  0, 0, 0, RUN, 4'b0000, 16'd1, 16'd0);
        cyc("r0_rd",   0, 1'b1, RD0,  0, 0, 0, RUN, 4'b0000, 16'd1, 16'd0);
        cyc("r0_fwd",  0, 1'b1, IDLE, 0, 0, 0, RUN, 4'b0000, 16'd1, 16'd0);
        pad(0, 16'd1, 16'd0);

        // Unused source does not match
        cyc("use_ld",  0, 1'b1, LW8U, 0, 0, 0, RUN, 4'b0000, 16'd1, 16'd0);
        cyc("use_rd",  0, 1'b1, RD8U, 0, 0, 0, RUN, 4'b0000, 16'd1, 16'd0);
        cyc("use_fwd", 0, 1'b1, IDLE, 0, 0, 0, RUN, 4'b0000, 16'd1, 16'd0);
        pad(0, 16'd1, 16'd0);

        // Taken branch in MEM coinciding with a load-use: branch wins
        cyc("br_lw",   0, 1'b1, LW8,  0, 0, 0, BR3 & RUN, 4'b0000, 16'd1, 16'd0);
        cyc("br_tkn",  0, 1'b1, ADD8, 1, 1, 0, BR3,       4'b0000, 16'd1, 16'd0);
        cyc("br_nt",   0, 1'b1, IDLE, 1, 0, 0, RUN,       4'b0000, 16'd1, 16'd1);
        pad(0, 16'd1, 16'd1);

        // Freeze for 3 cycles during a load-use, branch ignored while frozen
        cyc("frz_lw",  0, 1'b1, LW8,  0, 0, 0, RUN,   4'b0000, 16'd1, 16'd1);
        cyc("frz_1",   0, 1'b1, ADD8, 0, 0, 1, OFF,   4'b0000, 16'd1, 16'd1);
        cyc("frz_2",   0, 1'b1, ADD8, 1, 1, 1, OFF,   4'b0000, 16'd1, 16'd1);
        cyc("frz_3",   0, 1'b1, ADD8, 0, 0, 1, OFF,   4'b0000, 16'd1, 16'd1);
        cyc("frz_stl", 0, 1'b1, ADD8, 0, 0, 0, STALL, 4'b0000, 16'd1, 16'd1);
        cyc("frz_go",  0, 1'b1, ADD8, 0, 0, 0, RUN,   4'b0000, 16'd2, 16'd1);
        cyc("frz_fwd", 0, 1'b1, IDLE, 0, 0, 0, RUN,   4'b0010, 16'd2, 16'd1);
        pad(0, 16'd2, 16'd1);

        // Reset mid-stall abandons the stall
        cyc("rs_lw",   0, 1'b1, LW8,  0, 0, 0, RUN, 4'b0000, 16'd2, 16'd1);
        cyc("rs_rst",  0, 1'b0, ADD8, 0, 0, 0, OFF, 4'b0000, 16'd2, 16'd1);
        cyc("rs_go",   0, 1'b1, ADD8, 0, 0, 0, RUN, 4'b0000, 16'd0, 16'd0);
        cyc("rs_fwd",  0, 1'b1, IDLE, 0, 0, 0, RUN, 4'b0000, 16'd0, 16'd0);

        // DUT B: no forwarding, EX-stage branches, 4-bit counters
        rstA = 1'b0;
        cyc("B_rst",   1, 1'b0, IDLE, 0, 0, 0, OFF, 4'b0000, 16'd0, 16'd0);
        cyc("nf_add",  1, 1'b1, ADD3, 0, 0, 0, RUN,   4'b0000, 16'd0, 16'd0);
        cyc("nf_stl1", 1, 1'b1, SUB4, 0, 0, 0, STALL, 4'b0000, 16'd0, 16'd0);
        cyc("nf_stl2", 1, 1'b1, SUB4, 0, 0, 0, STALL, 4'b0000, 16'd1, 16'd0);
        cyc("nf_go",   1, 1'b1, SUB4, 0, 0, 0, RUN,   4'b0000, 16'd2, 16'd0);
        cyc("nf_ex",   1, 1'b1, IDLE, 0, 0, 0, RUN,   4'b0000, 16'd2, 16'd0);
        cyc("nf_br",   1, 1'b1, ADD5, 1, 1, 0, BR2,   4'b0000, 16'd2, 16'd0);
        cyc("nf_brd",  1, 1'b1, IDLE, 0, 0, 0, RUN,   4'b0000, 16'd2, 16'd1);

        // Saturation: 16 more stalls into a 4-bit counter
        eLu = 2;
        for (int it = 0; it < 8; it++) begin
            cyc("sat_lw",  1, 1'b1, LW8,  0, 0, 0, RUN,   4'b0000, 16'(eLu), 16'd1);
            cyc("sat_s1",  1, 1'b1, ADD8, 0, 0, 0, STALL, 4'b0000, 16'(eLu), 16'd1);
            eLu = (eLu < 15) ? eLu + 1 : 15;
            cyc("sat_s2",  1, 1'b1, ADD8, 0, 0, 0, STALL, 4'b0000, 16'(eLu), 16'd1);
            eLu = (eLu < 15) ? eLu + 1 : 15;
            cyc("sat_go",  1, 1'b1, ADD8, 0, 0, 0, RUN,   4'b0000, 16'(eLu), 16'd1);
            cyc("sat_idl", 1, 1'b1, IDLE, 0, 0, 0, RUN,   4'b0000, 16'(eLu), 16'd1);
        end
        cyc("sat_hold", 1, 1'b1, IDLE, 0, 0, 0, RUN, 4'b0000, 16'd15, 16'd1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
